vga_overlay_gen: RTL and testbench
==================================

// Module: vga_overlay_gen
// PURPOSE
//  Parametrised VGA timing generator with N_RECT prioritised, solid-colour rectangle overlays over a background colour.
//  Successor to the fixed-640x480 controller. Rectangle geometry is double-buffered: writes go to shadow registers and
//  are committed only at frame start, so there is no tearing. Sits between game logic (snake/sprite state) and the VGA DAC pins.
// PARAMETERS
//  COLOR_W  10   bits per colour channel
//  H_SYNC   96   | H_BP 48 | H_ACT 640 | H_FP 16: horizontal pixel counts
//  V_SYNC   2    | V_BP 33 | V_ACT 480 | V_FP 10: vertical line counts
//  COORD_W  10   counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
//  N_RECT   4    number of overlay rectangles (1..16); IDX_W = max(1,$clog2(N_RECT))
// PORTS
//  iCLK          in   1         pixel clock (25.175 MHz for defaults)
//  iRST          in   1         synchronous reset, active-high
//  iBG_Color     in   3*COLOR_W background {R,G,B} for active pixels with no hit
//  iCfg_Wr       in   1         write one rectangle into shadow set
//  iCfg_Idx      in   IDX_W     rectangle index
//  iCfg_En       in   1         rectangle enable
//  iCfg_X0/iCfg_X1 in COORD_W   inclusive left/right (active-area coords)
//  iCfg_Y0/iCfg_Y1 in COORD_W   inclusive top/bottom
//  iCfg_Color    in   3*COLOR_W rectangle {R,G,B}
//  iCommit       in   1         request shadow->active copy at next frame start
//  oCommit_Pend  out  1         commit requested, not yet applied
//  oVGA_R/G/B    out  COLOR_W   pixel colour, 0 outside active area
//  oVGA_H_SYNC   out  1         active-low hsync
//  oVGA_V_SYNC   out  1         active-low vsync
//  oVGA_BLANK    out  1         1 = active video (DAC blank_n)
//  oVGA_SYNC     out  1         constant 0
//  oVGA_CLOCK    out  1         = iCLK
//  oCoord_X/Y    out  COORD_W   active-area coordinate of the pixel currently on oVGA_*
//  oFrame_Start  out  1         1-cycle pulse, aligned with first sync cycle of a frame
// BEHAVIOUR
//  Counters: H_Cont 0..H_TOTAL-1 (H_TOTAL=H_SYNC+H_BP+H_ACT+H_FP), wraps to 0; V_Cont increments when H_Cont wraps,
//   wraps 0..V_TOTAL-1. Line order: sync, back porch, active, front porch. Active: H_Cont in [H_SYNC+H_BP, +H_ACT), same for V.
//  Pipeline: stage 1 registers sync/active/x=H_Cont-H_SYNC-H_BP, y likewise; stage 2 computes hits and registers all outputs.
//   Every output (colour, syncs, BLANK, Coord, Frame_Start) has latency 2 from its counter value; all mutually aligned.
//  Hit i: active_en[i] && X0<=x<=X1 && Y0<=y<=Y1 (unsigned). X0>X1 or Y0>Y1 never hits. Lowest index hit wins.
//  Colour: hit -> rect colour; active, no hit -> iBG_Color; inactive -> 0.
//  oCoord_X/Y hold last active value outside the active area.
//  Cfg write: iCfg_Wr stores all fields into shadow[iCfg_Idx] next edge; Idx>=N_RECT ignored; active set untouched.
//  Commit: iCommit sets pending. On cycle H_Cont==0 && V_Cont==0 with pending (or iCommit), active<=shadow and pending clears.
//   Same-cycle iCfg_Wr + commit edge: new write is included in the copy. iCommit while pending: no extra effect.
//  Reset: H/V_Cont=0, shadow and active cleared (all disabled), pending=0, colour=0, H/V_SYNC=1, BLANK=0, Coord=0,
//   Frame_Start=0. Reset mid-line: restarts at H=V=0; first valid output 2 cycles after iRST deasserts.
// CONFIGURATION
//  VGA_OVL_BORDER_EN defined: a 1-px frame on the active-area edge (x==0, x==H_ACT-1, y==0, y==V_ACT-1) is forced to
//   the highest-priority colour {R,G,B} = all ones, over rectangles. Undefined: no border; edge pixels follow normal hit rules.
// TESTING
//  Reset, default params -> hsync low for 96 clks every 800; vsync low for 2 lines every 525; BLANK high 640x480 clks per frame.
//  Rect0 {x 10..19, y 5..5, red}, commit -> next frame: exactly 10 red pixels on line y=5; oCoord_X 10..19 while red.
//  Rect0 and Rect1 overlap at (15,5); rect1 green -> pixel (15,5) red (index 0 wins); disabled rect0 -> green.
//  Write rect mid-frame without commit -> frame unchanged; commit at V=200 -> applied only from next frame start; Pend 1 until then.
//  X0=30, X1=20 -> no hits; Idx=N_RECT write -> no shadow change; iRST pulse mid-line -> counters 0, outputs reset values.
//  BORDER_EN build: pixel (0,0) and (639,479) white even under an enabled rect; without macro -> rect/background colour.

Source files
------------

// File: rtl/vga_overlay_gen.sv
// VGA timing generator with N_RECT prioritised solid-colour rectangle overlays and double-buffered geometry.
// Define VGA_OVL_BORDER_EN to force a white 1-px frame on the active-area edge above all rectangles.
module vga_overlay_gen #(
    parameter int COLOR_W = 10,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int H_ACT   = 640,
    parameter int H_FP    = 16,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int V_ACT   = 480,
    parameter int V_FP    = 10,
    parameter int COORD_W = 10,
    parameter int N_RECT  = 4,
    localparam int IDX_W  = (N_RECT > 1) ? $clog2(N_RECT) : 1
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    input  logic [3*COLOR_W-1:0]   iBG_Color,
    input  logic                   iCfg_Wr,
    input  logic [IDX_W-1:0]       iCfg_Idx,
    input  logic                   iCfg_En,
    input  logic [COORD_W-1:0]     iCfg_X0,
    input  logic [COORD_W-1:0]     iCfg_X1,
    input  logic [COORD_W-1:0]     iCfg_Y0,
    input  logic [COORD_W-1:0]     iCfg_Y1,
    input  logic [3*COLOR_W-1:0]   iCfg_Color,
    input  logic                   iCommit,
    output logic                   oCommit_Pend,
    output logic [COLOR_W-1:0]     oVGA_R,
    output logic [COLOR_W-1:0]     oVGA_G,
    output logic [COLOR_W-1:0]     oVGA_B,
    output logic                   oVGA_H_SYNC,
    output logic                   oVGA_V_SYNC,
    output logic                   oVGA_BLANK,
    output logic                   oVGA_SYNC,
    output logic                   oVGA_CLOCK,
    output logic [COORD_W-1:0]     oCoord_X,
    output logic [COORD_W-1:0]     oCoord_Y,
    output logic                   oFrame_Start
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;

    localparam logic [COORD_W-1:0] H_LAST     = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST     = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_SYNC_END = COORD_W'(H_SYNC);
    localparam logic [COORD_W-1:0] V_SYNC_END = COORD_W'(V_SYNC);
    localparam logic [COORD_W-1:0] H_ACT_BEG  = COORD_W'(H_SYNC + H_BP);
    localparam logic [COORD_W-1:0] V_ACT_BEG  = COORD_W'(V_SYNC + V_BP);
    localparam logic [COORD_W-1:0] H_ACT_END  = COORD_W'(H_SYNC + H_BP + H_ACT);
    localparam logic [COORD_W-1:0] V_ACT_END  = COORD_W'(V_SYNC + V_BP + V_ACT);

    typedef struct packed {
        logic                  en;
        logic [COORD_W-1:0]    x0;
        logic [COORD_W-1:0]    x1;
        logic [COORD_W-1:0]    y0;
        logic [COORD_W-1:0]    y1;
        logic [3*COLOR_W-1:0]  color;
    } rect_t;

    rect_t shadow_q [N_RECT];
    rect_t shadow_d [N_RECT];
    rect_t active_q [N_RECT];
    rect_t active_d [N_RECT];

    logic                  pend_q, pend_d;
    logic [COORD_W-1:0]    h_q, h_d, v_q, v_d;
    logic                  frame_start;
    logic                  commit_now;

    logic                  s1_hs_q, s1_vs_q, s1_act_q, s1_fs_q;
    logic [COORD_W-1:0]    s1_x_q, s1_y_q;

    logic [3*COLOR_W-1:0]  pix_color;
    logic [3*COLOR_W-1:0]  color_q;
    logic                  hsync_q, vsync_q, blank_q, fs_q;
    logic [COORD_W-1:0]    coord_x_q, coord_y_q;

    assign frame_start = (h_q == '0) && (v_q == '0);
    assign commit_now  = frame_start && (pend_q || iCommit);

    // A write landing on the commit edge must be part of the copy, so active takes shadow_d.
    always_comb begin
        shadow_d = shadow_q;
        for (int i = 0; i < N_RECT; i++) begin
            if (iCfg_Wr && (iCfg_Idx == IDX_W'(i))) begin
                shadow_d[i] = '{en: iCfg_En, x0: iCfg_X0, x1: iCfg_X1,
                                y0: iCfg_Y0, y1: iCfg_Y1, color: iCfg_Color};
            end
        end
        active_d = active_q;
        pend_d   = pend_q | iCommit;
        if (commit_now) begin
            active_d = shadow_d;
            pend_d   = 1'b0;
        end
    end

    always_comb begin
        h_d = (h_q == H_LAST) ? '0 : h_q + 1'b1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end
    end

    // Scan from the highest index down so the lowest-index hit is the one that sticks.
    always_comb begin
        pix_color = iBG_Color;
        for (int i = N_RECT - 1; i >= 0; i--) begin
            if (active_q[i].en &&
                (s1_x_q >= active_q[i].x0) && (s1_x_q <= active_q[i].x1) &&
                (s1_y_q >= active_q[i].y0) && (s1_y_q <= active_q[i].y1)) begin
                pix_color = active_q[i].color;
            end
        end
`ifdef VGA_OVL_BORDER_EN
        if ((s1_x_q == '0) || (s1_x_q == COORD_W'(H_ACT - 1)) ||
            (s1_y_q == '0) || (s1_y_q == COORD_W'(V_ACT - 1))) begin
            pix_color = '1;
        end
`endif
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            h_q       <= '0;
            v_q       <= '0;
            pend_q    <= 1'b0;
            for (int i = 0; i < N_RECT; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            s1_hs_q   <= 1'b1;
            s1_vs_q   <= 1'b1;
            s1_act_q  <= 1'b0;
            s1_fs_q   <= 1'b0;
            s1_x_q    <= '0;
            s1_y_q    <= '0;
            color_q   <= '0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            blank_q   <= 1'b0;
            fs_q      <= 1'b0;
            coord_x_q <= '0;
            coord_y_q <= '0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            pend_q   <= pend_d;
            shadow_q <= shadow_d;
            active_q <= active_d;

            s1_hs_q  <= (h_q >= H_SYNC_END);
            s1_vs_q  <= (v_q >= V_SYNC_END);
            s1_act_q <= (h_q >= H_ACT_BEG) && (h_q < H_ACT_END) &&
                        (v_q >= V_ACT_BEG) && (v_q < V_ACT_END);
            s1_fs_q  <= frame_start;
            s1_x_q   <= h_q - H_ACT_BEG;
            s1_y_q   <= v_q - V_ACT_BEG;

            color_q  <= s1_act_q ? pix_color : '0;
            hsync_q  <= s1_hs_q;
            vsync_q  <= s1_vs_q;
            blank_q  <= s1_act_q;
            fs_q     <= s1_fs_q;
            // Coordinates freeze at the last active pixel during blanking.
            if (s1_act_q) begin
                coord_x_q <= s1_x_q;
                coord_y_q <= s1_y_q;
            end
        end
    end

    assign oCommit_Pend = pend_q;
    assign oVGA_R       = color_q[3*COLOR_W-1 -: COLOR_W];
    assign oVGA_G       = color_q[2*COLOR_W-1 -: COLOR_W];
    assign oVGA_B       = color_q[COLOR_W-1:0];
    assign oVGA_H_SYNC  = hsync_q;
    assign oVGA_V_SYNC  = vsync_q;
    assign oVGA_BLANK   = blank_q;
    assign oVGA_SYNC    = 1'b0;
    assign oVGA_CLOCK   = iCLK;
    assign oCoord_X     = coord_x_q;
    assign oCoord_Y     = coord_y_q;
    assign oFrame_Start = fs_q;

endmodule

// File: tb/tb_vga_overlay_gen.sv
// Scoreboard bench for vga_overlay_gen on a shrunken raster; a behavioural raster model feeds an expected queue.
`timescale 1ns/1ps
module tb_vga_overlay_gen;

    localparam int COLOR_W = 4;
    localparam int H_SYNC  = 4;
    localparam int H_BP    = 3;
    localparam int H_ACT   = 20;
    localparam int H_FP    = 3;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 2;
    localparam int V_ACT   = 10;
    localparam int V_FP    = 2;
    localparam int COORD_W = 6;
    localparam int N_RECT  = 3;
    localparam int IDX_W   = 2;
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int FRAME   = H_TOTAL * V_TOTAL;
    localparam int CW      = 3 * COLOR_W;
    localparam int EXP_W   = CW + 3 + 2 * COORD_W + 1;
    localparam logic [EXP_W-1:0] RESET_EXP = {{CW{1'b0}}, 2'b11, 1'b0, {(2*COORD_W){1'b0}}, 1'b0};

    logic               iCLK, iRST, iCfg_Wr, iCfg_En, iCommit;
    logic [CW-1:0]      iBG_Color, iCfg_Color;
    logic [IDX_W-1:0]   iCfg_Idx;
    logic [COORD_W-1:0] iCfg_X0, iCfg_X1, iCfg_Y0, iCfg_Y1;
    logic               oCommit_Pend, oVGA_H_SYNC, oVGA_V_SYNC, oVGA_BLANK, oVGA_SYNC, oVGA_CLOCK, oFrame_Start;
    logic [COLOR_W-1:0] oVGA_R, oVGA_G, oVGA_B;
    logic [COORD_W-1:0] oCoord_X, oCoord_Y;

    vga_overlay_gen #(
        .COLOR_W(COLOR_W), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACT(H_ACT), .H_FP(H_FP),
        .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACT(V_ACT), .V_FP(V_FP),
        .COORD_W(COORD_W), .N_RECT(N_RECT)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iBG_Color(iBG_Color),
        .iCfg_Wr(iCfg_Wr), .iCfg_Idx(iCfg_Idx), .iCfg_En(iCfg_En),
        .iCfg_X0(iCfg_X0), .iCfg_X1(iCfg_X1), .iCfg_Y0(iCfg_Y0), .iCfg_Y1(iCfg_Y1),
        .iCfg_Color(iCfg_Color), .iCommit(iCommit), .oCommit_Pend(oCommit_Pend),
        .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B),
        .oVGA_H_SYNC(oVGA_H_SYNC), .oVGA_V_SYNC(oVGA_V_SYNC), .oVGA_BLANK(oVGA_BLANK),
        .oVGA_SYNC(oVGA_SYNC), .oVGA_CLOCK(oVGA_CLOCK),
        .oCoord_X(oCoord_X), .oCoord_Y(oCoord_Y), .oFrame_Start(oFrame_Start)
    );

    // ---------------- clock ----------------
    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // ---------------- reference model state ----------------
    typedef struct {
        bit            en;
        int            x0, x1, y0, y1;
        logic [CW-1:0] col;
    } mrect_t;

    mrect_t           m_shadow [N_RECT];
    mrect_t           m_active [N_RECT];
    bit               m_pend;
    logic [EXP_W-1:0] exp_q [$];
    int               n_checks = 0;
    int               n_fail   = 0;

    function automatic logic [CW-1:0] pick_color(input int x, input int y, input logic [CW-1:0] bg);
`ifdef VGA_OVL_BORDER_EN
        if (x == 0 || x == H_ACT - 1 || y == 0 || y == V_ACT - 1) return '1;
`endif
        for (int i = 0; i < N_RECT; i++) begin
            if (m_active[i].en && x >= m_active[i].x0 && x <= m_active[i].x1 &&
                y >= m_active[i].y0 && y <= m_active[i].y1) return m_active[i].col;
        end
        return bg;
    endfunction

    // Model: t counts cycles since reset; outputs appear two edges later, hence two reset entries.
    initial begin
        int t, h, v, x, y, last_x, last_y;
        bit act;
        logic [CW-1:0] col;
        t = 0; last_x = 0; last_y = 0;
        forever begin
            @(posedge iCLK);
            if (iRST) begin
                t = 0; last_x = 0; last_y = 0; m_pend = 0;
                for (int i = 0; i < N_RECT; i++) begin
                    m_shadow[i] = '{en: 0, x0: 0, x1: 0, y0: 0, y1: 0, col: '0};
                    m_active[i] = m_shadow[i];
                end
                exp_q.delete();
                exp_q.push_back(RESET_EXP);
                exp_q.push_back(RESET_EXP);
            end else begin
                h = t % H_TOTAL;
                v = (t / H_TOTAL) % V_TOTAL;
                if (iCfg_Wr && int'(iCfg_Idx) < N_RECT)
                    m_shadow[iCfg_Idx] = '{en: iCfg_En, x0: int'(iCfg_X0), x1: int'(iCfg_X1),
                                           y0: int'(iCfg_Y0), y1: int'(iCfg_Y1), col: iCfg_Color};
                if (h == 0 && v == 0 && (m_pend || iCommit)) begin
                    m_active = m_shadow;
                    m_pend   = 0;
                end else if (iCommit) begin
                    m_pend = 1;
                end
                x   = h - H_SYNC - H_BP;
                y   = v - V_SYNC - V_BP;
                act = (x >= 0 && x < H_ACT && y >= 0 && y < V_ACT);
                if (act) begin
                    last_x = x;
                    last_y = y;
                end
                col = act ? pick_color(x, y, iBG_Color) : '0;
                exp_q.push_back({col, h >= H_SYNC, v >= V_SYNC, act,
                                 COORD_W'(last_x), COORD_W'(last_y), (h == 0 && v == 0)});
                t++;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [EXP_W-1:0] e, got;
        int blank_cnt, hs_cnt, vs_cnt;
        bit frame_seen;
        blank_cnt = 0; hs_cnt = 0; vs_cnt = 0; frame_seen = 0;
        forever begin
            @(negedge iCLK);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {oVGA_R, oVGA_G, oVGA_B, oVGA_H_SYNC, oVGA_V_SYNC, oVGA_BLANK,
                       oCoord_X, oCoord_Y, oFrame_Start};
                n_checks++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL pixel @%0t: got %h expected %h", $time, got, e);
                end
                n_checks++;
                if (oCommit_Pend !== m_pend) begin
                    n_fail++;
                    $display("FAIL commit_pend @%0t: got %b expected %b", $time, oCommit_Pend, m_pend);
                end
                n_checks++;
                if (oVGA_SYNC !== 1'b0) begin
                    n_fail++;
                    $display("FAIL vga_sync @%0t: got %b expected 0", $time, oVGA_SYNC);
                end
            end
            if (iRST) frame_seen = 0;
            if (oFrame_Start === 1'b1) begin
                if (frame_seen) begin
                    n_checks++;
                    if (blank_cnt != H_ACT * V_ACT || hs_cnt != H_SYNC * V_TOTAL || vs_cnt != V_SYNC * H_TOTAL) begin
                        n_fail++;
                        $display("FAIL frame_counts: blank %0d hs_low %0d vs_low %0d expected %0d %0d %0d",
                                 blank_cnt, hs_cnt, vs_cnt, H_ACT * V_ACT, H_SYNC * V_TOTAL, V_SYNC * H_TOTAL);
                    end
                end
                blank_cnt = 0; hs_cnt = 0; vs_cnt = 0; frame_seen = 1;
            end
            if (oVGA_BLANK === 1'b1) blank_cnt++;
            if (oVGA_H_SYNC === 1'b0) hs_cnt++;
            if (oVGA_V_SYNC === 1'b0) vs_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge iCLK);
            #1;
        end
    endtask

    task automatic load_rect(input int idx, input bit en, input int x0, input int x1,
                             input int y0, input int y1, input logic [CW-1:0] col);
        iCfg_Wr = 1'b1; iCfg_Idx = IDX_W'(idx); iCfg_En = en;
        iCfg_X0 = COORD_W'(x0); iCfg_X1 = COORD_W'(x1);
        iCfg_Y0 = COORD_W'(y0); iCfg_Y1 = COORD_W'(y1); iCfg_Color = col;
    endtask

    task automatic write_rect(input int idx, input bit en, input int x0, input int x1,
                              input int y0, input int y1, input logic [CW-1:0] col);
        load_rect(idx, en, x0, x1, y0, y1, col);
        tick();
        iCfg_Wr = 1'b0;
    endtask

    task automatic commit();
        iCommit = 1'b1;
        tick();
        iCommit = 1'b0;
    endtask

    task automatic wait_frame_pulse();
        int k = 0;
        while (oFrame_Start !== 1'b1 && k < FRAME + 10) begin
            tick();
            k++;
        end
        n_checks++;
        if (k >= FRAME + 10) begin
            n_fail++;
            $display("FAIL frame_wait: no frame start within %0d cycles", FRAME + 10);
        end
    endtask

    // Background only changes while the raster is in vertical sync, away from any active pixel.
    task automatic set_bg(input logic [CW-1:0] c);
        int k = 0;
        while (oVGA_V_SYNC !== 1'b0 && k < FRAME + 10) begin
            tick();
            k++;
        end
        n_checks++;
        if (k >= FRAME + 10) begin
            n_fail++;
            $display("FAIL bg_wait: vsync not seen within %0d cycles", FRAME + 10);
        end else begin
            iBG_Color = c;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        iRST = 1'b1; iCommit = 1'b0; iCfg_Wr = 1'b0; iCfg_Idx = '0; iCfg_En = 1'b0;
        iCfg_X0 = '0; iCfg_X1 = '0; iCfg_Y0 = '0; iCfg_Y1 = '0; iCfg_Color = '0;
        iBG_Color = 12'h123;
        tick(3);
        iRST = 1'b0;
        tick(FRAME + 5);

        write_rect(0, 1, 10, 19, 5, 5, 12'hF00);
        commit();
        tick(2 * FRAME);
        write_rect(1, 1, 12, 17, 3, 7, 12'h0F0);
        commit();
        tick(FRAME + 50);
        write_rect(0, 0, 10, 19, 5, 5, 12'hF00);
        commit();
        tick(FRAME + 50);
        write_rect(2, 1, 15, 5, 0, 9, 12'h00F);
        commit();
        tick(FRAME + 50);
        write_rect(3, 1, 0, 19, 0, 9, 12'hFFF);
        commit();
        tick(FRAME + 50);

        write_rect(1, 1, 0, 19, 0, 9, 12'h0FF);
        tick(FRAME);
        tick(200);
        commit();
        commit();
        tick(FRAME + 50);

        wait_frame_pulse();
        tick(FRAME - 2);
        load_rect(0, 1, 2, 8, 1, 8, 12'hA5C);
        iCommit = 1'b1;
        tick();
        iCfg_Wr = 1'b0; iCommit = 1'b0;
        tick(FRAME);

        set_bg(12'h456);
        tick(FRAME);
        tick(137);
        iRST = 1'b1;
        tick();
        iRST = 1'b0;
        tick(FRAME + 20);

        for (int n = 0; n < 40; n++) begin
            int a;
            tick($urandom_range(0, 150));
            a = $urandom_range(0, 19);
            if (a < 10) begin
                write_rect($urandom_range(0, 3), 1'($urandom_range(0, 3) != 0),
                           $urandom_range(0, 22), $urandom_range(0, 22),
                           $urandom_range(0, 12), $urandom_range(0, 12), CW'($urandom));
            end else if (a < 15) begin
                commit();
            end else if (a < 19) begin
                set_bg(CW'($urandom));
            end else begin
                iRST = 1'b1;
                tick($urandom_range(1, 3));
                iRST = 1'b0;
            end
        end
        tick(2 * FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
